arith_core: RTL and testbench

//  Registered 64-bit integer arithmetic core for the LEGv8 datapath ALU.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/div_serial.sv | 84 ++++++++
 rtl/arith_core.sv | 155 +++++++++++++++
 tb/tb_arith_core.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// ============================================================================
// arith_pkg - op encodings and default widths shared by the arithmetic core
// Rev 1.0
// ============================================================================
`default_nettype none

package arith_pkg;

   localparam int DEFAULT_WIDTH     = 64;
   localparam int DEFAULT_DIV_WIDTH = 32;

   typedef logic [1:0] op_t;

   localparam op_t OP_ADD = 2'b00;
   localparam op_t OP_SUB = 2'b01;
   localparam op_t OP_DIV = 2'b10;
   localparam op_t OP_RSV = 2'b11;

endpackage : arith_pkg

`default_nettype wire

// File: rtl/div_serial.sv
// ============================================================================
// div_serial - unsigned restoring divider, one quotient bit per cycle, MSB first
// Rev 1.0  (DIV_REMAINDER_EN exposes the remainder port)
// ============================================================================
`default_nettype none

module div_serial
   import arith_pkg::*;
#(
   parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIV_WIDTH-1:0] dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_WIDTH-1:0] quotient
`ifdef DIV_REMAINDER_EN
   ,
   output logic [DIV_WIDTH-1:0] remainder
`endif
);

   localparam int CNT_W = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;

   logic                 r_busy;
   logic [CNT_W-1:0]     r_cnt;
   logic [DIV_WIDTH-1:0] r_quo;
   logic [DIV_WIDTH-1:0] r_rem;
   logic [DIV_WIDTH-1:0] r_div;

   logic [DIV_WIDTH:0]   w_shift;
   logic [DIV_WIDTH:0]   w_diff;
   logic                 w_ge;
   logic [DIV_WIDTH-1:0] w_rem_next;
   logic [DIV_WIDTH-1:0] w_quo_next;
   logic                 w_last;

   // The remainder is always below the divisor, so the shifted value fits in
   // DIV_WIDTH+1 bits and the top bit of the difference is a clean borrow.
   assign w_shift    = {r_rem, r_quo[DIV_WIDTH-1]};
   assign w_diff     = w_shift - {1'b0, r_div};
   assign w_ge       = ~w_diff[DIV_WIDTH];
   assign w_rem_next = w_ge ? w_diff[DIV_WIDTH-1:0] : w_shift[DIV_WIDTH-1:0];
   assign w_quo_next = {r_quo[DIV_WIDTH-2:0], w_ge};
   assign w_last     = r_busy && (r_cnt == CNT_W'(DIV_WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_busy <= 1'b0;
         r_cnt  <= '0;
         r_quo  <= '0;
         r_rem  <= '0;
         r_div  <= '0;
      end else if (start && !r_busy) begin
         r_busy <= 1'b1;
         r_cnt  <= '0;
         r_quo  <= dividend;
         r_rem  <= '0;
         r_div  <= divisor;
      end else if (r_busy) begin
         r_quo  <= w_quo_next;
         r_rem  <= w_rem_next;
         r_cnt  <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   // done flags the final iteration edge; quotient/remainder are the values
   // that edge produces, so the parent can register them on the same edge.
   assign busy     = r_busy;
   assign done     = w_last;
   assign quotient = w_quo_next;
`ifdef DIV_REMAINDER_EN
   assign remainder = w_rem_next;
`endif

endmodule : div_serial

`default_nettype wire

// File: rtl/arith_core.sv
// ============================================================================
// arith_core - registered add/sub plus iterative unsigned divide, start/busy/done
// Rev 1.0  (DIV_REMAINDER_EN adds the remainder output)
// ============================================================================
`default_nettype none

module arith_core
   import arith_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             zero,
   output logic             div_by_zero
`ifdef DIV_REMAINDER_EN
   ,
   output logic [DIV_WIDTH-1:0] remainder
`endif
);

   localparam logic [WIDTH-1:0] C_DBZ_RESULT = WIDTH'({DIV_WIDTH{1'b1}});

   logic                 r_done;
   logic [WIDTH-1:0]     r_result;
   logic                 r_carry;
   logic                 r_zero;
   logic                 r_dbz;

   logic                 w_accept;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH:0]       w_diff;
   logic [DIV_WIDTH-1:0] w_dividend;
   logic [DIV_WIDTH-1:0] w_divisor;
   logic                 w_divisor_zero;
   logic                 w_div_start;
   logic                 w_div_busy;
   logic                 w_div_done;
   logic [DIV_WIDTH-1:0] w_div_quo;

   assign w_accept       = start && !w_div_busy;
   assign w_sum          = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, c_in};
   assign w_diff         = {1'b0, a_in} + {1'b0, ~b_in} + (WIDTH+1)'(1);
   assign w_dividend     = a_in[DIV_WIDTH-1:0];
   assign w_divisor      = b_in[DIV_WIDTH-1:0];
   assign w_divisor_zero = (w_divisor == '0);
   // Divide-by-zero never enters the divider; it completes like add/sub.
   assign w_div_start    = w_accept && (op == OP_DIV) && !w_divisor_zero;

`ifdef DIV_REMAINDER_EN
   logic [DIV_WIDTH-1:0] r_rem;
   logic [DIV_WIDTH-1:0] w_div_rem;
`endif

   div_serial #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (w_div_start),
      .dividend  (w_dividend),
      .divisor   (w_divisor),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .quotient  (w_div_quo)
`ifdef DIV_REMAINDER_EN
      ,
      .remainder (w_div_rem)
`endif
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_done   <= 1'b0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_dbz    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         r_rem    <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            case (op)
               OP_ADD: begin
                  r_result <= w_sum[WIDTH-1:0];
                  r_carry  <= w_sum[WIDTH];
                  r_zero   <= (w_sum[WIDTH-1:0] == '0);
                  r_dbz    <= 1'b0;
                  r_done   <= 1'b1;
               end
               OP_SUB: begin
                  r_result <= w_diff[WIDTH-1:0];
                  r_carry  <= w_diff[WIDTH];
                  r_zero   <= (w_diff[WIDTH-1:0] == '0);
                  r_dbz    <= 1'b0;
                  r_done   <= 1'b1;
               end
               OP_DIV: begin
                  if (w_divisor_zero) begin
                     r_result <= C_DBZ_RESULT;
                     r_carry  <= 1'b0;
                     r_zero   <= 1'b0;
                     r_dbz    <= 1'b1;
                     r_done   <= 1'b1;
`ifdef DIV_REMAINDER_EN
                     r_rem    <= w_dividend;
`endif
                  end
               end
               default: begin
                  r_result <= '0;
                  r_carry  <= 1'b0;
                  r_zero   <= 1'b1;
                  r_dbz    <= 1'b0;
                  r_done   <= 1'b1;
               end
            endcase
         end else if (w_div_done) begin
            r_result <= WIDTH'(w_div_quo);
            r_carry  <= 1'b0;
            r_zero   <= (w_div_quo == '0);
            r_dbz    <= 1'b0;
            r_done   <= 1'b1;
`ifdef DIV_REMAINDER_EN
            r_rem    <= w_div_rem;
`endif
         end
      end
   end

   assign busy        = w_div_busy;
   assign done        = r_done;
   assign result      = r_result;
   assign carry_out   = r_carry;
   assign zero        = r_zero;
   assign div_by_zero = r_dbz;
`ifdef DIV_REMAINDER_EN
   assign remainder   = r_rem;
`endif

endmodule : arith_core

`default_nettype wire

// File: tb/tb_arith_core.sv
// ============================================================================
// tb_arith_core - directed self-checking bench for arith_core (DIV_REMAINDER_EN aware)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_arith_core;
   import arith_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [63:0] a_in;
   logic [63:0] b_in;
   logic        c_in;
   logic        busy;
   logic        done;
   logic [63:0] result;
   logic        carry_out;
   logic        zero;
   logic        div_by_zero;
`ifdef DIV_REMAINDER_EN
   logic [31:0] remainder;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   arith_core #(
      .WIDTH     (64),
      .DIV_WIDTH (32)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a_in        (a_in),
      .b_in        (b_in),
      .c_in        (c_in),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .carry_out   (carry_out),
      .zero        (zero),
      .div_by_zero (div_by_zero)
`ifdef DIV_REMAINDER_EN
      ,
      .remainder   (remainder)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one request for a single edge; returns 1 time unit after the accept edge.
   task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic c);
      start = 1'b1;
      op    = o;
      a_in  = a;
      b_in  = b;
      c_in  = c;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_single(input string tag, input logic [63:0] exp_res,
                               input logic exp_c, input logic exp_z, input logic exp_dbz);
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " busy"}, 64'(busy), 64'd0);
      check({tag, " result"}, result, exp_res);
      check({tag, " carry"}, 64'(carry_out), 64'(exp_c));
      check({tag, " zero"}, 64'(zero), 64'(exp_z));
      check({tag, " dbz"}, 64'(div_by_zero), 64'(exp_dbz));
   endtask

   task automatic run_div(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic inject);
      int cycles;
      int early_idle;
      cycles     = 0;
      early_idle = 0;
      issue(OP_DIV, a, b, 1'b0);
      check({tag, " busy after accept"}, 64'(busy), 64'd1);
      check({tag, " no early done"}, 64'(done), 64'd0);
      // Scramble operands; the divider must work from captured values.
      a_in = 64'h0123_4567_89AB_CDEF;
      b_in = 64'h0;
      while (!done && cycles < 40) begin
         if (inject && cycles == 5) begin
            start = 1'b1;
            op    = OP_ADD;
            a_in  = 64'd1;
            b_in  = 64'd1;
         end
         tick();
         start = 1'b0;
         cycles++;
         if (!done && !busy) early_idle++;
      end
      check({tag, " latency"}, 64'(cycles), 64'd32);
      check({tag, " busy stayed high"}, 64'(early_idle), 64'd0);
      check_single(tag, {32'h0, exp_q}, 1'b0, (exp_q == 32'h0), 1'b0);
`ifdef DIV_REMAINDER_EN
      check({tag, " remainder"}, 64'(remainder), 64'(exp_r));
`else
      if (exp_r != exp_r) $display("unreachable");
`endif
      tick();
      check({tag, " done one pulse"}, 64'(done), 64'd0);
      check({tag, " result held"}, result, {32'h0, exp_q});
   endtask

   initial begin
      int done_seen;
      rst_n = 1'b0;
      start = 1'b0;
      op    = OP_ADD;
      a_in  = '0;
      b_in  = '0;
      c_in  = 1'b0;
      tick();
      tick();
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", result, 64'd0);
      check("reset carry", 64'(carry_out), 64'd0);
      check("reset zero", 64'(zero), 64'd0);
      check("reset dbz", 64'(div_by_zero), 64'd0);
`ifdef DIV_REMAINDER_EN
      check("reset remainder", 64'(remainder), 64'd0);
`endif
      rst_n = 1'b1;
      tick();

      issue(OP_ADD, 64'd5, 64'd7, 1'b0);
      check_single("add 5+7", 64'd12, 1'b0, 1'b0, 1'b0);
      tick();
      check("add done one pulse", 64'(done), 64'd0);

      issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check_single("add wrap", 64'd0, 1'b1, 1'b1, 1'b0);

      issue(OP_ADD, 64'd10, 64'd20, 1'b1);
      check_single("add cin", 64'd31, 1'b0, 1'b0, 1'b0);

      issue(OP_SUB, 64'd3, 64'd5, 1'b0);
      check_single("sub 3-5", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

      issue(OP_SUB, 64'd9, 64'd9, 1'b0);
      check_single("sub 9-9", 64'd0, 1'b1, 1'b1, 1'b0);

      issue(OP_SUB, 64'd10, 64'd4, 1'b1);
      check_single("sub cin ignored", 64'd6, 1'b1, 1'b0, 1'b0);

      issue(OP_RSV, 64'd77, 64'd3, 1'b1);
      check_single("reserved", 64'd0, 1'b0, 1'b1, 1'b0);

      // Two adds on consecutive edges.
      start = 1'b1;
      op    = OP_ADD;
      a_in  = 64'd1;
      b_in  = 64'd2;
      c_in  = 1'b0;
      tick();
      check_single("b2b first", 64'd3, 1'b0, 1'b0, 1'b0);
      a_in = 64'd3;
      b_in = 64'd4;
      tick();
      start = 1'b0;
      check_single("b2b second", 64'd7, 1'b0, 1'b0, 1'b0);
      tick();
      check("b2b done low", 64'(done), 64'd0);

      run_div("div 100/7", 64'd100, 64'd7, 32'd14, 32'd2, 1'b1);
      run_div("div upper ignored", 64'hDEAD_0000_FFFF_FFFF, 64'h1234_0000_0000_0001,
              32'hFFFF_FFFF, 32'd0, 1'b0);
      run_div("div 5/9", 64'd5, 64'd9, 32'd0, 32'd5, 1'b0);

      issue(OP_DIV, 64'd123, 64'd0, 1'b0);
      check_single("div by zero", 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
`ifdef DIV_REMAINDER_EN
      check("div by zero remainder", 64'(remainder), 64'd123);
`endif
      issue(OP_ADD, 64'd2, 64'd3, 1'b0);
      check_single("add clears dbz", 64'd5, 1'b0, 1'b0, 1'b0);
`ifdef DIV_REMAINDER_EN
      check("add keeps remainder", 64'(remainder), 64'd123);
`endif

      // Reset in the middle of a divide aborts it silently.
      issue(OP_DIV, 64'd1000, 64'd3, 1'b0);
      repeat (8) tick();
      check("abort busy before reset", 64'(busy), 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort busy", 64'(busy), 64'd0);
      check("abort done", 64'(done), 64'd0);
      check("abort result", result, 64'd0);
      done_seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) done_seen++;
      end
      check("abort no done", 64'(done_seen), 64'd0);

      issue(OP_ADD, 64'd5, 64'd7, 1'b0);
      check_single("add after abort", 64'd12, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule : tb_arith_core

`default_nettype wire
